// File: rtl/byte_link_rx.sv
// Receive side of the 8-bit byte link: fall-through FIFO plus per-frame
// modulo-256 checksum and saturating byte count, reported once per frame.
`timescale 1ns/1ps
module byte_link_rx #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PTR_W:0]   count,
    output logic             frame_active,
    output logic             frame_done,
    output logic [7:0]       frame_sum,
    output logic [7:0]       frame_len
);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    typedef enum logic {IDLE, IN_FRAME} state_t;

    state_t           state;
    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [7:0]       acc_sum;
    logic [7:0]       acc_len;
    logic             push;
    logic             pop;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Ready is gated by the reset input itself so it reads 0 while held in reset.
    assign in_ready     = rst && (count != FULL_CNT);
    assign out_valid    = (count != '0);
    assign out_data     = out_valid ? mem[rd_ptr] : 8'h00;
    assign push         = in_valid && in_ready;
    assign pop          = out_valid && out_ready;
    assign frame_active = (state == IN_FRAME);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Frame accounting follows pushes only; the last byte folds straight into the report.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            acc_sum    <= 8'h00;
            acc_len    <= 8'h00;
            frame_done <= 1'b0;
            frame_sum  <= 8'h00;
            frame_len  <= 8'h00;
        end else begin
            frame_done <= 1'b0;
            if (push) begin
                if (in_last) begin
                    frame_sum  <= acc_sum + in_data;
                    frame_len  <= sat_inc(acc_len);
                    acc_sum    <= 8'h00;
                    acc_len    <= 8'h00;
                    frame_done <= 1'b1;
                    state      <= IDLE;
                end else begin
                    acc_sum <= acc_sum + in_data;
                    acc_len <= sat_inc(acc_len);
                    state   <= IN_FRAME;
                end
            end
        end
    end
endmodule

// File: tb/tb_byte_link_rx.sv
// Scoreboard bench for byte_link_rx: a queue-based model tracks FIFO contents
// and whole-frame byte lists; a negedge monitor compares every cycle.
`timescale 1ns/1ps
module tb_byte_link_rx;
    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   in_data = 8'h00;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic         out_ready = 1'b0;
    logic         in_ready;
    logic [7:0]   out_data;
    logic         out_valid;
    logic [PTR_W:0] count;
    logic         frame_active;
    logic         frame_done;
    logic [7:0]   frame_sum;
    logic [7:0]   frame_len;

    byte_link_rx #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .count(count), .frame_active(frame_active), .frame_done(frame_done),
        .frame_sum(frame_sum), .frame_len(frame_len)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int ready_mode = 1;

    logic [7:0]  data_q[$];
    logic [7:0]  cur_frame[$];
    logic [15:0] frame_q[$];
    bit          model_in_frame = 0;
    logic [7:0]  last_sum = 8'h00;
    logic [7:0]  last_len = 8'h00;
    logic [15:0] fexp;
    int          fsum;
    bit          m_push, m_pop;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_frame_active"}, frame_active, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_frame_sum"}, frame_sum, 0);
        chk({tag, "_frame_len"}, frame_len, 0);
    endtask

    // Monitor: compare against the model, then apply this cycle's transfers to it.
    always @(negedge clk) begin
        if (rst) begin
            if (frame_q.size() != 0) begin
                fexp = frame_q.pop_front();
                last_sum = fexp[15:8];
                last_len = fexp[7:0];
                chk("frame_done", frame_done, 1);
            end else begin
                chk("frame_done_idle", frame_done, 0);
            end
            chk("frame_sum", frame_sum, last_sum);
            chk("frame_len", frame_len, last_len);
            chk("count", count, data_q.size());
            chk("in_ready", in_ready, data_q.size() != DEPTH);
            chk("out_valid", out_valid, data_q.size() != 0);
            chk("frame_active", frame_active, model_in_frame);
            m_pop  = (data_q.size() != 0) && out_ready;
            m_push = in_valid && (data_q.size() != DEPTH);
            if (m_pop) chk("out_data", out_data, data_q.pop_front());
            if (m_push) begin
                data_q.push_back(in_data);
                cur_frame.push_back(in_data);
                if (in_last) begin
                    fsum = 0;
                    foreach (cur_frame[i]) fsum += cur_frame[i];
                    fexp[15:8] = 8'(fsum % 256);
                    fexp[7:0]  = (cur_frame.size() > 255) ? 8'd255 : 8'(cur_frame.size());
                    frame_q.push_back(fexp);
                    cur_frame.delete();
                    model_in_frame = 0;
                end else begin
                    model_in_frame = 1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic send(input logic [7:0] d, input logic l);
        int n;
        bit acc;
        n = 0;
        acc = 0;
        in_data = d;
        in_valid = 1'b1;
        in_last = l;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
            if (!acc && n > 200) begin
                chk("send_timeout", 0, 1);
                acc = 1;
            end
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b0;
        #1 check_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Short frame, consumer always ready
        ready_mode = 0;
        send(8'h01, 0); send(8'h02, 0); send(8'h03, 1); idle();
        repeat (3) @(posedge clk); #1;
        chk("f123_sum", frame_sum, 8'h06);
        chk("f123_len", frame_len, 3);

        // Fill the FIFO with the consumer stalled, then release it
        ready_mode = 1;
        repeat (2) @(posedge clk); #1;
        fork
            begin
                for (int i = 0; i < 5; i++) send(8'hA0 + 8'(i), i == 4);
                idle();
            end
            begin
                repeat (9) @(posedge clk); #1;
                chk("full_count", count, 4);
                chk("full_in_ready", in_ready, 0);
                ready_mode = 0;
            end
        join
        repeat (8) @(posedge clk); #1;

        // Long frame: length saturates, sum wraps
        ready_mode = 2;
        for (int i = 0; i < 300; i++) send(8'hFF, i == 299);
        idle();
        ready_mode = 0;
        repeat (10) @(posedge clk); #1;
        chk("long_sum", frame_sum, 8'hD4);
        chk("long_len", frame_len, 255);

        // Back-to-back single-byte frames
        send(8'h10, 1); send(8'h20, 1); send(8'h30, 1); idle();
        repeat (3) @(posedge clk); #1;
        chk("single_sum", frame_sum, 8'h30);
        chk("single_len", frame_len, 1);

        // Reset in the middle of a frame with two bytes buffered
        ready_mode = 1;
        repeat (2) @(posedge clk); #1;
        send(8'h11, 0); send(8'h22, 0); idle();
        @(posedge clk); #2;
        rst = 1'b0;
        #1 check_zero("midreset");
        data_q.delete(); cur_frame.delete(); frame_q.delete();
        model_in_frame = 0; last_sum = 8'h00; last_len = 8'h00;
        repeat (2) @(posedge clk); #1;
        rst = 1'b1;
        ready_mode = 0;
        send(8'h05, 1); idle();
        repeat (3) @(posedge clk); #1;
        chk("post_reset_sum", frame_sum, 8'h05);
        chk("post_reset_len", frame_len, 1);

        // Randomized traffic
        ready_mode = 2;
        for (int i = 0; i < 250; i++) begin
            send(8'($urandom), $urandom_range(0, 5) == 0);
            if ($urandom_range(0, 3) == 0) begin
                idle();
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        send(8'($urandom), 1);
        idle();
        ready_mode = 0;
        repeat (12) @(posedge clk); #1;
        chk("drained_data", data_q.size(), 0);
        chk("drained_frames", frame_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
